// File: rtl/aes_result_router.sv
// AES result return path: buffers core results in a small FIFO and routes them to the
// key-schedule or data sink by the mode latched at job start, tracking chaining state.
module aes_result_router #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [1:0]        sel_i,
   input  logic [CNT_W-1:0]  len_i,
   input  logic [DATA_W-1:0] res_i,
   input  logic              rvalid_i,
   output logic              rready_o,
   output logic [DATA_W-1:0] key_o,
   output logic              kvalid_o,
   input  logic              kready_i,
   output logic [DATA_W-1:0] out_o,
   output logic              ovalid_o,
   input  logic              oready_i,
   output logic [DATA_W-1:0] chain_o,
   output logic              cvalid_o,
   output logic [CNT_W-1:0]  blk_cnt_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state;
   logic [1:0]        mode;
   logic [CNT_W-1:0]  len;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              fifo_full, fifo_has, push, pop, key_mode;

   assign fifo_full = (count == (AW+1)'(DEPTH));
   assign fifo_has  = (count != '0);
   assign key_mode  = (mode == 2'd0);

   // Readiness depends only on registered state, never on sink readiness.
   assign rready_o = (state == RUN) && !fifo_full && (blk_cnt_o < len);
   assign push     = rready_o && rvalid_i;
   assign pop      = fifo_has && (key_mode ? kready_i : oready_i);

   assign kvalid_o = fifo_has && key_mode;
   assign ovalid_o = fifo_has && !key_mode;
   assign key_o    = kvalid_o ? mem[rd_ptr] : '0;
   assign out_o    = ovalid_o ? mem[rd_ptr] : '0;
   assign busy_o   = (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= res_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         mode      <= '0;
         len       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         blk_cnt_o <= '0;
         chain_o   <= '0;
         cvalid_o  <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;

         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase

         if (push) begin
            blk_cnt_o <= blk_cnt_o + CNT_W'(1);
            if (!key_mode) begin
               chain_o  <= res_i;
               cvalid_o <= 1'b1;
            end
         end

         unique case (state)
            IDLE: begin
               if (start_i) begin
                  if (sel_i == 2'd3) begin
                     err_o <= 1'b1;
                  end else begin
                     mode      <= sel_i;
                     len       <= len_i;
                     blk_cnt_o <= '0;
                     cvalid_o  <= 1'b0;
                     if (len_i == '0) done_o <= 1'b1;
                     else             state  <= RUN;
                  end
               end
            end
            RUN: begin
               if (push && (blk_cnt_o + CNT_W'(1) == len)) state <= DRAIN;
            end
            DRAIN: begin
               // Leave on the edge that pops the final entry, not a cycle later.
               if (!fifo_has || (count == (AW+1)'(1) && pop)) begin
                  done_o <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_result_router.sv
// Directed self-checking bench for aes_result_router: routing, back-pressure, chaining,
// error/zero-length starts, stalls, mid-job reset and start-during-run.
module tb_aes_result_router;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         start_i = 1'b0;
   logic [1:0]   sel_i = '0;
   logic [15:0]  len_i = '0;
   logic [127:0] res_i = '0;
   logic         rvalid_i = 1'b0;
   logic         rready_o;
   logic [127:0] key_o;
   logic         kvalid_o;
   logic         kready_i = 1'b0;
   logic [127:0] out_o;
   logic         ovalid_o;
   logic         oready_i = 1'b0;
   logic [127:0] chain_o;
   logic         cvalid_o;
   logic [15:0]  blk_cnt_o;
   logic         busy_o;
   logic         done_o;
   logic         err_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [127:0] kq[$];
   logic [127:0] oq[$];
   int kval_seen = 0;
   int oval_seen = 0;
   int done_cnt  = 0;

   aes_result_router #(.DATA_W(128), .DEPTH(2), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sel_i(sel_i), .len_i(len_i),
      .res_i(res_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .key_o(key_o), .kvalid_o(kvalid_o), .kready_i(kready_i),
      .out_o(out_o), .ovalid_o(ovalid_o), .oready_i(oready_i),
      .chain_o(chain_o), .cvalid_o(cvalid_o), .blk_cnt_o(blk_cnt_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   // Sink-side monitor, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (kvalid_o && kready_i) kq.push_back(key_o);
      if (ovalid_o && oready_i) oq.push_back(out_o);
      if (kvalid_o) kval_seen++;
      if (ovalid_o) oval_seen++;
      if (done_o)   done_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_sb();
      kq.delete();
      oq.delete();
      kval_seen = 0;
      oval_seen = 0;
      done_cnt  = 0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done_o && n < 30) begin
         tick();
         n++;
      end
      check(tag, 128'(done_o), 128'd1);
   endtask

   task automatic start_job(input logic [1:0] s, input logic [15:0] l);
      start_i = 1'b1;
      sel_i   = s;
      len_i   = l;
      tick();
      start_i = 1'b0;
   endtask

   logic [127:0] v4 [3];
   logic [15:0]  rpat, opat;
   int           idx;
   logic         acc, seen_done, extra_taken;

   initial begin
      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_rready", 128'(rready_o), 128'd0);
      check("rst_kvalid", 128'(kvalid_o), 128'd0);
      check("rst_ovalid", 128'(ovalid_o), 128'd0);
      check("rst_chain", chain_o, 128'd0);
      check("rst_busy_done_err", {busy_o, done_o, err_o, cvalid_o}, 128'd0);
      check("rst_cnt", 128'(blk_cnt_o), 128'd0);
      rst_i = 1'b0;
      tick();

      // 1: mode 0, len 4, back-to-back into an always-ready key sink
      clear_sb();
      kready_i = 1'b1;
      start_job(2'd0, 16'd4);
      check("t1_busy", 128'(busy_o), 128'd1);
      for (int i = 0; i < 4; i++) begin
         check("t1_rready", 128'(rready_o), 128'd1);
         rvalid_i = 1'b1;
         res_i    = 128'hA0 + 128'(i);
         tick();
      end
      rvalid_i = 1'b0;
      check("t1_cnt", 128'(blk_cnt_o), 128'd4);
      check("t1_rready_drain", 128'(rready_o), 128'd0);
      wait_done("t1_done");
      tick();
      check("t1_done_pulse", 128'(done_o), 128'd0);
      check("t1_done_cnt", 128'(done_cnt), 128'd1);
      check("t1_nkeys", 128'(kq.size()), 128'd4);
      for (int i = 0; i < 4 && i < kq.size(); i++) check("t1_key", kq[i], 128'hA0 + 128'(i));
      check("t1_kbeats", 128'(kval_seen), 128'd4);
      check("t1_no_ovalid", 128'(oval_seen), 128'd0);
      check("t1_cvalid", 128'(cvalid_o), 128'd0);
      check("t1_idle", 128'(busy_o), 128'd0);
      kready_i = 1'b0;

      // 2: mode 1, len 3, blocked data sink fills the FIFO
      clear_sb();
      oready_i = 1'b0;
      start_job(2'd1, 16'd3);
      rvalid_i = 1'b1;
      check("t2_rready0", 128'(rready_o), 128'd1);
      res_i = 128'h11;
      tick();
      check("t2_rready1", 128'(rready_o), 128'd1);
      res_i = 128'h22;
      tick();
      check("t2_full", 128'(rready_o), 128'd0);
      check("t2_chain", chain_o, 128'h22);
      check("t2_cvalid", 128'(cvalid_o), 128'd1);
      check("t2_cnt2", 128'(blk_cnt_o), 128'd2);
      check("t2_out_head", out_o, 128'h11);
      check("t2_kvalid", 128'(kvalid_o), 128'd0);
      res_i = 128'h33;
      tick();
      check("t2_hold_cnt", 128'(blk_cnt_o), 128'd2);
      oready_i = 1'b1;
      check("t2_no_passthru", 128'(rready_o), 128'd0);
      tick();
      check("t2_reopen", 128'(rready_o), 128'd1);
      tick();
      rvalid_i = 1'b0;
      check("t2_cnt3", 128'(blk_cnt_o), 128'd3);
      check("t2_chain3", chain_o, 128'h33);
      wait_done("t2_done");
      tick();
      check("t2_nout", 128'(oq.size()), 128'd3);
      for (int i = 0; i < 3 && i < oq.size(); i++) check("t2_out", oq[i], 128'h11 * 128'(i + 1));
      check("t2_done_cnt", 128'(done_cnt), 128'd1);
      oready_i = 1'b0;

      // 3: illegal mode rejected; zero-length job completes without running
      clear_sb();
      start_job(2'd3, 16'd5);
      check("t3_err", 128'(err_o), 128'd1);
      check("t3_busy", 128'(busy_o), 128'd0);
      tick();
      check("t3_err_pulse", 128'(err_o), 128'd0);
      check("t3_chain_kept", 128'(cvalid_o), 128'd1);
      start_job(2'd2, 16'd0);
      check("t3_len0_done", 128'(done_o), 128'd1);
      check("t3_len0_busy", 128'(busy_o), 128'd0);
      check("t3_len0_cvalid", 128'(cvalid_o), 128'd0);
      check("t3_len0_rready", 128'(rready_o), 128'd0);
      tick();
      check("t3_len0_pulse", {done_o, busy_o, err_o}, 128'd0);

      // 4: mode 2, len 2 with source/sink stalls and a surplus third beat
      clear_sb();
      v4[0] = 128'hC0FFEE01;
      v4[1] = 128'hC0FFEE02;
      v4[2] = 128'hC0FFEE03;
      rpat = 16'b1011_0110_1101_1011;
      opat = 16'b0110_1011_0011_1101;
      idx = 0;
      seen_done = 1'b0;
      extra_taken = 1'b0;
      start_job(2'd2, 16'd2);
      for (int c = 0; c < 40 && !seen_done; c++) begin
         rvalid_i = rpat[c % 16];
         oready_i = opat[c % 16];
         res_i    = v4[idx];
         acc      = rvalid_i && rready_o;
         if (idx >= 2 && rready_o) extra_taken = 1'b1;
         tick();
         if (acc && idx < 2) idx++;
         if (done_o) seen_done = 1'b1;
      end
      rvalid_i = 1'b0;
      check("t4_done", 128'(seen_done), 128'd1);
      check("t4_extra_ignored", 128'(extra_taken), 128'd0);
      check("t4_cnt", 128'(blk_cnt_o), 128'd2);
      check("t4_nout", 128'(oq.size()), 128'd2);
      for (int i = 0; i < 2 && i < oq.size(); i++) check("t4_out", oq[i], v4[i]);
      check("t4_chain", chain_o, v4[1]);
      check("t4_cvalid", 128'(cvalid_o), 128'd1);
      check("t4_no_kvalid", 128'(kval_seen), 128'd0);
      oready_i = 1'b0;
      tick();
      check("t4_done_cnt", 128'(done_cnt), 128'd1);

      // 5: reset while running with a full FIFO, then a clean job
      clear_sb();
      start_job(2'd1, 16'd5);
      rvalid_i = 1'b1;
      res_i = 128'h55;
      tick();
      res_i = 128'h66;
      tick();
      rvalid_i = 1'b0;
      check("t5_full", 128'(rready_o), 128'd0);
      #2 rst_i = 1'b1;
      #1;
      check("t5_rst_out", out_o, 128'd0);
      check("t5_rst_chain", chain_o, 128'd0);
      check("t5_rst_flags", {rready_o, kvalid_o, ovalid_o, cvalid_o, busy_o, done_o, err_o}, 128'd0);
      check("t5_rst_cnt", 128'(blk_cnt_o), 128'd0);
      tick();
      rst_i = 1'b0;
      tick();
      kready_i = 1'b1;
      start_job(2'd0, 16'd1);
      rvalid_i = 1'b1;
      res_i = 128'h77;
      tick();
      rvalid_i = 1'b0;
      wait_done("t5_done");
      tick();
      check("t5_nkeys", 128'(kq.size()), 128'd1);
      if (kq.size() > 0) check("t5_key", kq[0], 128'h77);
      check("t5_no_out", 128'(oq.size()), 128'd0);
      kready_i = 1'b0;

      // 6: a second start during RUN must not disturb the running job
      clear_sb();
      oready_i = 1'b1;
      start_job(2'd1, 16'd2);
      start_i = 1'b1;
      sel_i = 2'd0;
      len_i = 16'd5;
      rvalid_i = 1'b1;
      res_i = 128'h81;
      tick();
      start_i = 1'b0;
      res_i = 128'h82;
      tick();
      rvalid_i = 1'b0;
      check("t6_cnt", 128'(blk_cnt_o), 128'd2);
      wait_done("t6_done");
      tick();
      check("t6_nout", 128'(oq.size()), 128'd2);
      if (oq.size() > 1) check("t6_out1", oq[1], 128'h82);
      check("t6_no_kvalid", 128'(kval_seen), 128'd0);
      check("t6_idle", 128'(busy_o), 128'd0);
      check("t6_chain", chain_o, 128'h82);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
